// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, default cache size, parcel helper.
// The MISS_B state exists only when IFETCH_RVC_EN is defined.
package ifetch_unit_pkg;

   localparam int unsigned ICACHE_IDX_W_DEF = 6;

   typedef enum logic [1:0] {
      IfIdle,
      IfMissA
`ifdef IFETCH_RVC_EN
      ,
      IfMissB
`endif
   } if_state_e;

   // A parcel whose two low bits are 11 starts a 32-bit instruction.
   function automatic logic parcel_is_full(input logic [15:0] parcel);
      return parcel[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Decoder-side fetch handshake and memctrl word-read handshake of the fetch unit.
// master: the fetch unit itself; slave: decoder plus memory controller.
interface ifetch_unit_if;

   logic        if_enable;
   logic [31:0] if_addr;
   logic        inst_ready;
   logic        is_c;
   logic [31:0] inst_val;

   logic        mc_req;
   logic [31:0] mc_addr;
   logic        mc_ready;
   logic [31:0] mc_data;

   modport master (
      input  if_enable,
      input  if_addr,
      input  mc_ready,
      input  mc_data,
      output inst_ready,
      output is_c,
      output inst_val,
      output mc_req,
      output mc_addr
   );

   modport slave (
      output if_enable,
      output if_addr,
      output mc_ready,
      output mc_data,
      input  inst_ready,
      input  is_c,
      input  inst_val,
      input  mc_req,
      input  mc_addr
   );

endinterface

// File: rtl/ifetch_unit_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage with async read, sync write.
// Read port B (the straddle word) is present only when IFETCH_RVC_EN is defined.
module ifetch_unit_icache_array
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned IDX_W = ICACHE_IDX_W_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [29:0] i_wword,
   input  logic [31:0] i_wdata,
   input  logic [29:0] i_word_a,
   output logic        o_hit_a,
   output logic [31:0] o_data_a
`ifdef IFETCH_RVC_EN
   ,
   input  logic [29:0] i_word_b,
   output logic        o_hit_b,
   output logic [31:0] o_data_b
`endif
);

   localparam int unsigned Lines = 2 ** IDX_W;
   localparam int unsigned TagW  = 30 - IDX_W;

   logic [Lines-1:0] r_valid;
   logic [TagW-1:0]  r_tag  [Lines];
   logic [31:0]      r_data [Lines];

   logic [IDX_W-1:0] w_widx;
   logic [IDX_W-1:0] w_idx_a;

   assign w_widx  = i_wword[IDX_W-1:0];
   assign w_idx_a = i_word_a[IDX_W-1:0];

   assign o_hit_a  = r_valid[w_idx_a] && (r_tag[w_idx_a] == i_word_a[29:IDX_W]);
   assign o_data_a = r_data[w_idx_a];

`ifdef IFETCH_RVC_EN
   logic [IDX_W-1:0] w_idx_b;

   assign w_idx_b  = i_word_b[IDX_W-1:0];
   assign o_hit_b  = r_valid[w_idx_b] && (r_tag[w_idx_b] == i_word_b[29:IDX_W]);
   assign o_data_b = r_data[w_idx_b];
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[w_widx] <= 1'b1;
      end
   end

   // Tag/data need no reset: valid bits gate every use.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[w_widx]  <= i_wword[29:IDX_W];
         r_data[w_widx] <= i_wdata;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: icache lookup, miss handling toward memctrl, registered output.
// IFETCH_RVC_EN enables 2-byte PCs, compressed parcels and straddling 32-bit instructions.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int unsigned ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          clear,
   ifetch_unit_if.master bus
);

   if_state_e   r_state;
   logic        r_out_valid;
   logic [31:0] r_out_addr;
   logic [31:0] r_out_inst;
   logic        r_mc_req;
   logic [31:0] r_mc_addr;

   logic [29:0] w_word_a;
   logic        w_hit_a;
   logic [31:0] w_data_a;
   logic        w_out_match;
   logic        w_lookup;
   logic        w_fill;
   logic        w_hit;
   logic [31:0] w_inst;
   logic [29:0] w_miss_word;

`ifdef IFETCH_RVC_EN
   logic        r_out_c;
   logic [29:0] w_word_b;
   logic        w_hit_b;
   logic [31:0] w_data_b;
   logic [15:0] w_lo;
   logic        w_full;
   logic        w_need_b;
`endif

   assign w_word_a    = bus.if_addr[31:2];
   assign w_out_match = r_out_valid && (r_out_addr == bus.if_addr);
   assign w_lookup    = bus.if_enable && !clear && !w_out_match;
   assign w_fill      = rdy_in && !rst_in && (r_state != IfIdle) && bus.mc_ready;

   ifetch_unit_icache_array #(
      .IDX_W (ICACHE_IDX_W)
   ) u_array (
      .i_clk    (clk_in),
      .i_rst    (rst_in),
      .i_we     (w_fill),
      .i_wword  (r_mc_addr[31:2]),
      .i_wdata  (bus.mc_data),
      .i_word_a (w_word_a),
      .o_hit_a  (w_hit_a),
      .o_data_a (w_data_a)
`ifdef IFETCH_RVC_EN
      ,
      .i_word_b (w_word_b),
      .o_hit_b  (w_hit_b),
      .o_data_b (w_data_b)
`endif
   );

`ifdef IFETCH_RVC_EN
   // Word B wraps naturally in 30 bits, so 0xFFFFFFFC pairs with word 0.
   assign w_word_b    = w_word_a + 30'd1;
   assign w_lo        = bus.if_addr[1] ? w_data_a[31:16] : w_data_a[15:0];
   assign w_full      = parcel_is_full(w_lo);
   assign w_need_b    = bus.if_addr[1] && w_full;
   assign w_hit       = w_hit_a && (!w_need_b || w_hit_b);
   assign w_miss_word = w_hit_a ? w_word_b : w_word_a;
   assign w_inst      = !w_full        ? {16'h0000, w_lo} :
                        bus.if_addr[1] ? {w_data_b[15:0], w_data_a[31:16]} :
                                         w_data_a;
   assign bus.is_c    = r_out_c;
`else
   assign w_hit       = w_hit_a;
   assign w_miss_word = w_word_a;
   assign w_inst      = w_data_a;
   assign bus.is_c    = 1'b0;

`ifndef SYNTHESIS
   a_no_half_pc : assert property (@(posedge clk_in) disable iff (rst_in)
      bus.if_enable |-> !bus.if_addr[1]);
`endif
`endif

   assign bus.inst_ready = w_out_match && bus.if_enable && !clear;
   assign bus.inst_val   = r_out_inst;
   assign bus.mc_req     = r_mc_req;
   assign bus.mc_addr    = r_mc_addr;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= IfIdle;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_inst  <= '0;
         r_mc_req    <= 1'b0;
         r_mc_addr   <= '0;
`ifdef IFETCH_RVC_EN
         r_out_c     <= 1'b0;
`endif
      end else if (rdy_in) begin
         if (clear) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            IfIdle: begin
               if (w_lookup) begin
                  if (w_hit) begin
                     r_out_valid <= 1'b1;
                     r_out_addr  <= bus.if_addr;
                     r_out_inst  <= w_inst;
`ifdef IFETCH_RVC_EN
                     r_out_c     <= !w_full;
`endif
                  end else begin
                     r_out_valid <= 1'b0;
                     r_mc_req    <= 1'b1;
                     r_mc_addr   <= {w_miss_word, 2'b00};
`ifdef IFETCH_RVC_EN
                     r_state     <= w_hit_a ? IfMissB : IfMissA;
`else
                     r_state     <= IfMissA;
`endif
                  end
               end
            end
            // Miss states: hold the request; a flush does not abort it.
            default: begin
               if (bus.mc_ready) begin
                  r_mc_req <= 1'b0;
                  r_state  <= IfIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory responder, abstract cache/instruction model,
// per-cycle output compare, directed fetch scenarios (RVC scenarios under IFETCH_RVC_EN).
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   localparam int unsigned IdxW   = ICACHE_IDX_W_DEF;
   localparam int unsigned Lines  = 1 << IdxW;
   localparam int          MemLat = 3;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   logic clr;

   ifetch_unit_if bus ();

   ifetch_unit #(
      .ICACHE_IDX_W (IdxW)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .clear  (clr),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int          n_tests;
   int          n_fail;
   bit          mon_en;
   logic [31:0] mem [0:1023];
   logic [31:0] q_mc [$];
   logic [29:0] m_word [Lines];
   bit          m_valid [Lines];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {is_c, inst} for a PC, straight from the memory image.
   function automatic logic [32:0] model_fetch(input logic [31:0] pc);
      logic [31:0] wa;
      wa = mem[pc[11:2]];
`ifdef IFETCH_RVC_EN
      begin
         logic [9:0]  ib;
         logic [31:0] wb;
         logic [15:0] lo;
         ib = pc[11:2] + 10'd1;
         wb = mem[ib];
         lo = pc[1] ? wa[31:16] : wa[15:0];
         if (lo[1:0] != 2'b11) return {1'b1, 16'h0000, lo};
         if (!pc[1]) return {1'b0, wa};
         return {1'b0, wb[15:0], wa[31:16]};
      end
`else
      return {1'b0, wa};
`endif
   endfunction

   function automatic bit m_need_b(input logic [31:0] pc);
`ifdef IFETCH_RVC_EN
      logic [31:0] wa;
      logic [15:0] lo;
      wa = mem[pc[11:2]];
      lo = pc[1] ? wa[31:16] : wa[15:0];
      return pc[1] && (lo[1:0] == 2'b11);
`else
      return pc[1] && 1'b0;
`endif
   endfunction

   function automatic bit m_hit(input logic [29:0] w);
      return m_valid[w[IdxW-1:0]] && (m_word[w[IdxW-1:0]] == w);
   endfunction

   function automatic void m_fill(input logic [29:0] w);
      m_valid[w[IdxW-1:0]] = 1'b1;
      m_word[w[IdxW-1:0]]  = w;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < int'(Lines); i++) m_valid[i] = 1'b0;
   endfunction

   // Present pc and count cycles until inst_ready; latency predicted from the cache model.
   task automatic fetch(input logic [31:0] pc, input int lit_lat);
      logic [29:0] wa;
      logic [29:0] wb;
      bit          ha;
      bit          hb;
      bit          nb;
      int          exp_lat;
      int          lat;
      wa = pc[31:2];
      wb = wa + 30'd1;
      nb = m_need_b(pc);
      ha = m_hit(wa);
      hb = m_hit(wb);
      if (ha && (!nb || hb))      exp_lat = 1;
      else if (!ha && nb && !hb)  exp_lat = 2 * MemLat + 3;
      else                        exp_lat = MemLat + 2;
      @(negedge clk);
      bus.if_addr   = pc;
      bus.if_enable = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.inst_ready && lat < 100);
      check("fetch_ready", {31'b0, bus.inst_ready}, 32'd1);
      check("fetch_latency", lat, exp_lat);
      if (lit_lat > 0) check("fetch_latency_lit", lat, lit_lat);
      m_fill(wa);
      if (nb) m_fill(wb);
   endtask

   // Memory controller: answers each request MemLat cycles after it first appears.
   initial begin : responder
      int rcnt;
      rcnt         = 0;
      bus.mc_ready = 1'b0;
      bus.mc_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rcnt         = 0;
            bus.mc_ready = 1'b0;
         end else if (bus.mc_ready) begin
            bus.mc_ready = 1'b0;
         end else if (bus.mc_req && rdy) begin
            rcnt++;
            if (rcnt == MemLat) begin
               bus.mc_ready = 1'b1;
               bus.mc_data  = mem[bus.mc_addr[11:2]];
               q_mc.push_back(bus.mc_addr);
               rcnt = 0;
            end
         end
      end
   end

   // Per-cycle compare against the model, sampled 1 time unit after the active edge.
   initial begin : compare
      logic        prev_req;
      logic [31:0] prev_addr;
      logic [32:0] exp;
      prev_req  = 1'b0;
      prev_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (bus.inst_ready) begin
               exp = model_fetch(bus.if_addr);
               check("inst_val", bus.inst_val, exp[31:0]);
               check("is_c", {31'b0, bus.is_c}, {31'b0, exp[32]});
            end
            if (!rst && prev_req && !bus.mc_ready) begin
               check("mc_req_hold", {31'b0, bus.mc_req}, 32'd1);
               check("mc_addr_hold", bus.mc_addr, prev_addr);
            end
            if (bus.mc_req) check("mc_addr_align", {30'b0, bus.mc_addr[1:0]}, 32'd0);
         end
         prev_req  = bus.mc_req;
         prev_addr = bus.mc_addr;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int lat;
      n_tests = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0003 + (i << 8);
      mem[0]    = 32'h00A0_0093;
      mem[1023] = 32'h1283_0001;
      mem[12'h080] = 32'h0093_4501;
      mem[12'h081] = 32'h1234_0517;
      mem[12'h0C0] = 32'h0513_AAAA;
      mem[12'h0C1] = 32'hBBBB_0640;

      rst           = 1'b1;
      rdy           = 1'b1;
      clr           = 1'b0;
      bus.if_enable = 1'b0;
      bus.if_addr   = '0;
      repeat (3) @(negedge clk);
      check("rst_mc_req", {31'b0, bus.mc_req}, 32'd0);
      check("rst_mc_addr", bus.mc_addr, 32'd0);
      check("rst_inst_val", bus.inst_val, 32'd0);
      check("rst_is_c", {31'b0, bus.is_c}, 32'd0);
      bus.if_enable = 1'b1;
      #1;
      check("rst_inst_ready", {31'b0, bus.inst_ready}, 32'd0);
      bus.if_enable = 1'b0;
      m_reset();
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Cold miss, then hit after another line is fetched.
      q_mc.delete();
      fetch(32'h0, 5);
      check("cold_inst", bus.inst_val, 32'h00A0_0093);
      check("cold_is_c", {31'b0, bus.is_c}, 32'd0);
      check("cold_mc_count", q_mc.size(), 32'd1);
      check("cold_mc_addr", q_mc[0], 32'h0);
      fetch(32'h4, 5);
      fetch(32'h0, 1);
      check("refetch_inst", bus.inst_val, 32'h00A0_0093);

      // Decoder stall holds the output; moving to a cached PC costs one cycle.
      fetch(32'hC, 5);
      fetch(32'h8, 5);
      q_mc.delete();
      repeat (5) begin
         @(negedge clk);
         check("stall_ready", {31'b0, bus.inst_ready}, 32'd1);
         check("stall_mc_req", {31'b0, bus.mc_req}, 32'd0);
      end
      bus.if_addr = 32'hC;
      #1;
      check("switch_ready_low", {31'b0, bus.inst_ready}, 32'd0);
      @(negedge clk);
      check("switch_ready_high", {31'b0, bus.inst_ready}, 32'd1);
      check("switch_inst", bus.inst_val, mem[3]);
      check("stall_no_mem", q_mc.size(), 32'd0);

      // Flush mid-miss: line 0x40 still fills, then 0x100 misses.
      q_mc.delete();
      @(negedge clk);
      bus.if_addr = 32'h40;
      repeat (2) @(negedge clk);
      check("clr_mc_req", {31'b0, bus.mc_req}, 32'd1);
      check("clr_mc_addr", bus.mc_addr, 32'h40);
      clr         = 1'b1;
      bus.if_addr = 32'h100;
      @(negedge clk);
      clr = 1'b0;
      lat = 0;
      while (!bus.inst_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("clr_ready", {31'b0, bus.inst_ready}, 32'd1);
      check("clr_mc_count", q_mc.size(), 32'd2);
      check("clr_mc_first", q_mc[0], 32'h40);
      check("clr_mc_second", q_mc[1], 32'h100);
      m_fill(30'h10);
      m_fill(30'h40);
      fetch(32'h40, 1);

      // rdy_in low freezes the output register.
      @(negedge clk);
      rdy         = 1'b0;
      bus.if_addr = 32'h4;
      repeat (3) begin
         @(negedge clk);
         check("frozen_ready", {31'b0, bus.inst_ready}, 32'd0);
         check("frozen_inst", bus.inst_val, mem[16]);
      end
      rdy = 1'b1;
      @(negedge clk);
      check("thaw_ready", {31'b0, bus.inst_ready}, 32'd1);
      check("thaw_inst", bus.inst_val, mem[1]);

      // Reset clears every valid bit; index conflicts evict.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst2_inst_ready", {31'b0, bus.inst_ready}, 32'd0);
      bus.if_enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      q_mc.delete();
      fetch(32'h0, 5);
      check("rst2_mc_addr", q_mc[0], 32'h0);
      fetch(32'h100, 5);
      fetch(32'h0, 5);

`ifdef IFETCH_RVC_EN
      fetch(32'h200, 5);
      check("rvc_inst", bus.inst_val, 32'h0000_4501);
      check("rvc_is_c", {31'b0, bus.is_c}, 32'd1);
      q_mc.delete();
      fetch(32'h202, 5);
      check("half_inst", bus.inst_val, 32'h0517_0093);
      check("half_is_c", {31'b0, bus.is_c}, 32'd0);
      check("half_mc_addr", q_mc[0], 32'h204);
      fetch(32'h206, 1);
      check("upper_rvc_inst", bus.inst_val, 32'h0000_1234);
      check("upper_rvc_is_c", {31'b0, bus.is_c}, 32'd1);
      q_mc.delete();
      fetch(32'h302, 9);
      check("straddle_inst", bus.inst_val, 32'h0640_0513);
      check("straddle_mc_count", q_mc.size(), 32'd2);
      check("straddle_mc_first", q_mc[0], 32'h300);
      check("straddle_mc_second", q_mc[1], 32'h304);
      q_mc.delete();
      fetch(32'hFFFF_FFFE, 9);
      check("wrap_inst", bus.inst_val, 32'h0093_1283);
      check("wrap_mc_first", q_mc[0], 32'hFFFF_FFFC);
      check("wrap_mc_second", q_mc[1], 32'h0);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
